prog_tick_divider: RTL and testbench

Multi-channel, runtime-programmable clock divider and tick generator. It is the parametrised successor to the fixed cascaded 1 Hz prescaler. Each of NCH channels has its own divisor, a one-cycle tick strobe and a toggling square-wave output. Divisors can be rewritten on the fly, either glitch-free at the next wrap or as an immediate restart. It sits between the system clock and slow consumers: display refresh, debouncers, seconds counters.

---
 rtl/prog_tick_divider.sv | 142 ++++++++++++++
 tb/tb_prog_tick_divider.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_divider.sv
// prog_tick_divider: NCH independent runtime-programmable tick/square-wave dividers.
// Each channel counts enabled edges up to its active divisor. A write either
// restarts the channel immediately or is parked in a shadow register until the
// channel's next wrap.
module prog_tick_divider #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned NCH         = 4,
    parameter int unsigned DEFAULT_DIV = 100000000,
    parameter int unsigned CH_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr,
    input  logic             wr_en,
    input  logic             wr_imm,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   sq,
    output logic [NCH-1:0]   pend,
    output logic             err
);

    // One extra bit so the channel range check also works when NCH == 2^CH_W.
    localparam int unsigned CHS_W = CH_W + 1;

    logic [CNT_W-1:0] cnt_q    [NCH];
    logic [CNT_W-1:0] cnt_d    [NCH];
    logic [CNT_W-1:0] div_q    [NCH];
    logic [CNT_W-1:0] div_d    [NCH];
    logic [CNT_W-1:0] shadow_q [NCH];
    logic [CNT_W-1:0] shadow_d [NCH];
    logic [NCH-1:0]   tick_d;
    logic [NCH-1:0]   sq_d;
    logic [NCH-1:0]   pend_d;
    logic             err_d;

    logic             wr_legal;
    logic             wr_bad;
    logic [NCH-1:0]   hit;
    logic [NCH-1:0]   wrap;

    // Write decode and per-channel wrap detection.
    always_comb begin
        wr_legal = wr_en && (wr_div != '0) && ({1'b0, wr_ch} < CHS_W'(NCH));
        wr_bad   = wr_en && !wr_legal;
        hit      = '0;
        wrap     = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i]  = wr_legal && (wr_ch == CH_W'(i));
            wrap[i] = (cnt_q[i] == (div_q[i] - CNT_W'(1)));
        end
    end

    // Next-state per channel: clr > immediate write > wrap/count > hold.
    always_comb begin
        err_d = err;
        if (clr) begin
            err_d = 1'b0;
        end else if (wr_bad) begin
            err_d = 1'b1;
        end

        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            div_d[i]    = div_q[i];
            shadow_d[i] = shadow_q[i];
            pend_d[i]   = pend[i];
            tick_d[i]   = 1'b0;
            sq_d[i]     = sq[i];

            if (clr) begin
                cnt_d[i]  = '0;
                sq_d[i]   = 1'b0;
                pend_d[i] = 1'b0;
                if (pend[i]) begin
                    div_d[i] = shadow_q[i];
                end
                // Writes coinciding with clr always take effect at once.
                if (hit[i]) begin
                    div_d[i]    = wr_div;
                    shadow_d[i] = wr_div;
                end
            end else if (hit[i] && wr_imm) begin
                div_d[i]    = wr_div;
                shadow_d[i] = wr_div;
                cnt_d[i]    = '0;
                pend_d[i]   = 1'b0;
            end else if (enable) begin
                if (wrap[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq[i];
                    pend_d[i] = 1'b0;
                    // A deferred write landing on the wrap edge is applied right here.
                    if (hit[i]) begin
                        div_d[i]    = wr_div;
                        shadow_d[i] = wr_div;
                    end else if (pend[i]) begin
                        div_d[i] = shadow_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (hit[i]) begin
                        shadow_d[i] = wr_div;
                        pend_d[i]   = 1'b1;
                    end
                end
            end else if (hit[i]) begin
                shadow_d[i] = wr_div;
                pend_d[i]   = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= CNT_W'(DEFAULT_DIV);
                shadow_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            tick <= '0;
            sq   <= '0;
            pend <= '0;
            err  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                div_q[i]    <= div_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            tick <= tick_d;
            sq   <= sq_d;
            pend <= pend_d;
            err  <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_tick_divider.sv
// Bench for prog_tick_divider: edge-level behavioural model plus directed scenario.
module tb_prog_tick_divider;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DDIV  = 4;
    localparam int unsigned CH_W  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             clr = 1'b0;
    logic             wr_en = 1'b0;
    logic             wr_imm = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0] wr_div = '0;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   sq;
    logic [NCH-1:0]   pend;
    logic             err;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    prog_tick_divider #(
        .CNT_W(CNT_W), .NCH(NCH), .DEFAULT_DIV(DDIV), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr(clr),
        .wr_en(wr_en), .wr_imm(wr_imm), .wr_ch(wr_ch), .wr_div(wr_div),
        .tick(tick), .sq(sq), .pend(pend), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: each channel has a period, a count of enabled edges since its last
    // restart, and an optional parked period; a tick occurs when the count reaches the period.
    int m_period [NCH];
    int m_elapsed[NCH];
    int m_shadow [NCH];
    bit m_pend   [NCH];
    bit m_tick   [NCH];
    bit m_sq     [NCH];
    bit m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_period[c] = DDIV; m_elapsed[c] = 0; m_shadow[c] = DDIV;
                m_pend[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
            end
            m_err = 0;
        end else begin
            bit legal;
            legal = wr_en && (wr_div != 0) && (int'(wr_ch) < NCH);
            if (clr) m_err = 0;
            else if (wr_en && !legal) m_err = 1;
            for (int c = 0; c < NCH; c++) begin
                bit h;
                h = legal && (int'(wr_ch) == c);
                if (clr) begin
                    m_elapsed[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
                    if (m_pend[c]) m_period[c] = m_shadow[c];
                    m_pend[c] = 0;
                    if (h) m_period[c] = int'(wr_div);
                end else if (h && wr_imm) begin
                    m_period[c] = int'(wr_div); m_elapsed[c] = 0;
                    m_tick[c] = 0; m_pend[c] = 0;
                end else if (enable) begin
                    m_elapsed[c]++;
                    if (m_elapsed[c] == m_period[c]) begin
                        m_elapsed[c] = 0; m_tick[c] = 1; m_sq[c] = !m_sq[c];
                        if (h) m_period[c] = int'(wr_div);
                        else if (m_pend[c]) m_period[c] = m_shadow[c];
                        m_pend[c] = 0;
                    end else begin
                        m_tick[c] = 0;
                        if (h) begin m_shadow[c] = int'(wr_div); m_pend[c] = 1; end
                    end
                end else begin
                    m_tick[c] = 0;
                    if (h) begin m_shadow[c] = int'(wr_div); m_pend[c] = 1; end
                end
            end
        end
    end

    function automatic logic [NCH-1:0] pack(input bit v [NCH]);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = v[c];
        return r;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("mdl_tick", 32'(tick), 32'(pack(m_tick)));
            check("mdl_sq",   32'(sq),   32'(pack(m_sq)));
            check("mdl_pend", 32'(pend), 32'(pack(m_pend)));
            check("mdl_err",  32'(err),  32'(m_err));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk_on = 1'b1;
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_sq",   32'(sq),   32'h0);
        check("rst_pend", 32'(pend), 32'h0);
        check("rst_err",  32'(err),  32'h0);

        // Default divisor 4 on all channels.
        reset = 1'b1; enable = 1'b1;
        cyc(3);
        check("e3_tick", 32'(tick), 32'h0);
        cyc(1);
        check("e4_tick", 32'(tick), 32'hF);
        check("e4_sq",   32'(sq),   32'hF);
        cyc(4);
        check("e8_tick", 32'(tick), 32'hF);
        check("e8_sq",   32'(sq),   32'h0);

        // Deferred write ch1 div=2 while its count is 1.
        cyc(1);
        wr_en = 1'b1; wr_imm = 1'b0; wr_ch = 4'd1; wr_div = 8'd2;
        cyc(1);
        wr_en = 1'b0;
        check("e10_pend", 32'(pend), 32'h2);
        check("e10_tick", 32'(tick), 32'h0);
        cyc(2);
        check("e12_tick", 32'(tick), 32'hF);
        check("e12_pend", 32'(pend), 32'h0);
        check("e12_sq",   32'(sq),   32'hF);
        cyc(1);
        check("e13_tick", 32'(tick), 32'h0);
        cyc(1);
        check("e14_tick", 32'(tick), 32'h2);
        check("e14_sq",   32'(sq),   32'hD);

        // Immediate write ch2 div=3 while its count is 2.
        wr_en = 1'b1; wr_imm = 1'b1; wr_ch = 4'd2; wr_div = 8'd3;
        cyc(1);
        wr_en = 1'b0; wr_imm = 1'b0;
        check("e15_tick", 32'(tick), 32'h0);
        check("e15_sq2",  32'(sq[2]), 32'h1);
        cyc(1);
        check("e16_tick", 32'(tick), 32'hB);
        cyc(1);
        check("e17_tick", 32'(tick), 32'h0);
        cyc(1);
        check("e18_tick", 32'(tick), 32'h6);
        check("e18_sq",   32'(sq),   32'h0);

        // Illegal writes: zero divisor, then out-of-range channel.
        wr_en = 1'b1; wr_ch = 4'd0; wr_div = 8'd0;
        cyc(1);
        check("e19_err", 32'(err), 32'h1);
        wr_ch = 4'd5; wr_div = 8'd7;
        cyc(1);
        wr_en = 1'b0;
        check("e20_err",  32'(err),  32'h1);
        check("e20_pend", 32'(pend), 32'h0);
        cyc(1);
        check("e21_err", 32'(err), 32'h1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("e22_err",  32'(err),  32'h0);
        check("e22_sq",   32'(sq),   32'h0);
        check("e22_tick", 32'(tick), 32'h0);
        cyc(2);
        check("e24_tick", 32'(tick), 32'h2);
        check("e24_sq",   32'(sq),   32'h2);

        // Hold enable low 10 edges; deferred write on ch3 parks meanwhile.
        enable = 1'b0;
        cyc(2);
        wr_en = 1'b1; wr_imm = 1'b0; wr_ch = 4'd3; wr_div = 8'd5;
        cyc(1);
        wr_en = 1'b0;
        check("e27_pend", 32'(pend), 32'h8);
        check("e27_tick", 32'(tick), 32'h0);
        cyc(7);
        check("e34_pend", 32'(pend), 32'h8);
        enable = 1'b1;
        cyc(1);
        check("e35_tick", 32'(tick), 32'h4);
        cyc(1);
        check("e36_tick", 32'(tick), 32'hB);
        check("e36_pend", 32'(pend), 32'h0);

        // Deferred write ch0 div=1 coinciding with its wrap at edge 40.
        cyc(3);
        wr_en = 1'b1; wr_imm = 1'b0; wr_ch = 4'd0; wr_div = 8'd1;
        cyc(1);
        wr_en = 1'b0;
        check("e40_tick0", 32'(tick[0]), 32'h1);
        check("e40_pend",  32'(pend),    32'h0);
        cyc(1);
        check("e41_tick0", 32'(tick[0]), 32'h1);
        check("e41_sq0",   32'(sq[0]),   32'h1);
        cyc(1);
        check("e42_tick0", 32'(tick[0]), 32'h1);
        check("e42_sq0",   32'(sq[0]),   32'h0);
        cyc(1);
        check("e43_sq0",   32'(sq[0]),   32'h1);

        // Async reset between clock edges.
        #2 reset = 1'b0;
        #1;
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_sq",   32'(sq),   32'h0);
        check("arst_pend", 32'(pend), 32'h0);
        check("arst_err",  32'(err),  32'h0);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
